// File: rtl/exp_fp32_128_pkg.sv
// Types and constants shared by the fp32 exp datapath and its stream controller.
package exp_fp32_128_pkg;

   localparam int DATA_WIDTH = 128;
   localparam int LANES      = 4;

   typedef logic [31:0]         fp32_t;
   typedef fp32_t [LANES-1:0]   fp32x4_t;

   // One result FIFO entry: datapath output tagged with the tlast of its source beat.
   typedef struct packed {
      logic    last;
      fp32x4_t data;
   } result_t;

endpackage

// File: rtl/exp_fp32_128_stream_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; read data reads as zero when empty.
module exp_fp32_128_stream_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 129
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             push;
   logic             pop;

   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign push     = wr_en & ~full;
   assign rd_valid = (count != '0);
   assign pop      = rd_en & rd_valid;
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

   // NOTE: the storage array is deliberately left out of reset; only pointers and count need a known state.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The credit scheme upstream must never let a write reach a full FIFO.
   a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/exp_fp32_128_stream_ctrl.sv
// Credit-based flow control around the fixed-latency fp32 exp datapath, with tlast realignment.
// Optional performance counters are built only when EXP_STREAM_PERF_EN is defined.
module exp_fp32_128_stream_ctrl
   import exp_fp32_128_pkg::*;
#(
   parameter int LATENCY    = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                    aresetn,
   input  logic                    aclk,
   input  logic [DATA_WIDTH-1:0]   s_axi4s_tdata,
   input  logic                    s_axi4s_tlast,
   input  logic                    s_axi4s_tvalid,
   output logic                    s_axi4s_tready,
   output logic [DATA_WIDTH-1:0]   calc_in_data,
   output logic                    calc_in_valid,
   input  logic [DATA_WIDTH-1:0]   calc_out_data,
   input  logic                    calc_out_valid,
   output logic [DATA_WIDTH-1:0]   m_axi4s_tdata,
   output logic                    m_axi4s_tlast,
   output logic                    m_axi4s_tvalid,
   input  logic                    m_axi4s_tready,
   output logic                    busy,
   output logic                    err_underrun,
   output logic [CNT_WIDTH-1:0]    perf_in_beats,
   output logic [CNT_WIDTH-1:0]    perf_stall_cycles
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int USED_W = CNT_W + 1;
   localparam logic [USED_W-1:0] CREDITS = USED_W'(FIFO_DEPTH);

   logic [CNT_W-1:0]  inflight;
   logic [CNT_W-1:0]  fifo_count;
   logic [USED_W-1:0] used;
   logic              ready_en;
   logic              accept;
   logic              ret_ok;
   logic [LATENCY:0]  tlast_pipe;
   result_t           wr_entry;
   result_t           rd_entry;

   // Credits come only from registered state, so m_axi4s_tready has no path to s_axi4s_tready.
   assign used           = USED_W'(inflight) + USED_W'(fifo_count);
   assign s_axi4s_tready = ready_en & (used < CREDITS);
   assign accept         = s_axi4s_tvalid & s_axi4s_tready;
   assign ret_ok         = calc_out_valid & (inflight != '0);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ready_en      <= 1'b0;
         calc_in_valid <= 1'b0;
         calc_in_data  <= '0;
         tlast_pipe    <= '0;
         inflight      <= '0;
         err_underrun  <= 1'b0;
      end else begin
         ready_en      <= 1'b1;
         calc_in_valid <= accept;
         if (accept) calc_in_data <= s_axi4s_tdata;
         // tlast enters with the accept and exits in the cycle its result returns.
         tlast_pipe    <= {tlast_pipe[LATENCY-1:0], accept & s_axi4s_tlast};
         case ({accept, ret_ok})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
         if (calc_out_valid && (inflight == '0)) err_underrun <= 1'b1;
      end
   end

   assign wr_entry.last = tlast_pipe[LATENCY];
   assign wr_entry.data = calc_out_data;

   exp_fp32_128_stream_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(result_t))
   ) u_fifo (
      .clk      (aclk),
      .rst_n    (aresetn),
      .wr_en    (ret_ok),
      .wr_data  (wr_entry),
      .rd_en    (m_axi4s_tready),
      .rd_data  (rd_entry),
      .rd_valid (m_axi4s_tvalid),
      .count    (fifo_count)
   );

   assign m_axi4s_tdata = rd_entry.data;
   assign m_axi4s_tlast = rd_entry.last;
   assign busy          = (inflight != '0) | m_axi4s_tvalid;

`ifdef EXP_STREAM_PERF_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         perf_in_beats     <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (accept) perf_in_beats <= perf_in_beats + 1'b1;
         if (s_axi4s_tvalid && !s_axi4s_tready) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      end
   end
`else
   assign perf_in_beats     = '0;
   assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_exp_fp32_128_stream_ctrl.sv
// Directed bench for exp_fp32_128_stream_ctrl; the datapath is modelled as a LATENCY-cycle delay adding 1 per lane.
module tb_exp_fp32_128_stream_ctrl;

   localparam int LATENCY    = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int CNT_WIDTH  = 32;

   logic                 aresetn;
   logic                 aclk;
   logic [127:0]         s_axi4s_tdata;
   logic                 s_axi4s_tlast;
   logic                 s_axi4s_tvalid;
   logic                 s_axi4s_tready;
   logic [127:0]         calc_in_data;
   logic                 calc_in_valid;
   logic [127:0]         calc_out_data;
   logic                 calc_out_valid;
   logic [127:0]         m_axi4s_tdata;
   logic                 m_axi4s_tlast;
   logic                 m_axi4s_tvalid;
   logic                 m_axi4s_tready;
   logic                 busy;
   logic                 err_underrun;
   logic [CNT_WIDTH-1:0] perf_in_beats;
   logic [CNT_WIDTH-1:0] perf_stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [127:0] data;
      logic         last;
      int           t;
   } beat_t;
   beat_t out_q[$];

   exp_fp32_128_stream_ctrl #(
      .LATENCY    (LATENCY),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .aresetn           (aresetn),
      .aclk              (aclk),
      .s_axi4s_tdata     (s_axi4s_tdata),
      .s_axi4s_tlast     (s_axi4s_tlast),
      .s_axi4s_tvalid    (s_axi4s_tvalid),
      .s_axi4s_tready    (s_axi4s_tready),
      .calc_in_data      (calc_in_data),
      .calc_in_valid     (calc_in_valid),
      .calc_out_data     (calc_out_data),
      .calc_out_valid    (calc_out_valid),
      .m_axi4s_tdata     (m_axi4s_tdata),
      .m_axi4s_tlast     (m_axi4s_tlast),
      .m_axi4s_tvalid    (m_axi4s_tvalid),
      .m_axi4s_tready    (m_axi4s_tready),
      .busy              (busy),
      .err_underrun      (err_underrun),
      .perf_in_beats     (perf_in_beats),
      .perf_stall_cycles (perf_stall_cycles)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc++;

   // Lanes {b, b+1, b+2, b+3} with lane0 in the low word; lane-wise +1 of mk(b) is mk(b+1).
   function automatic logic [127:0] mk(input int unsigned b);
      logic [31:0] l0;
      l0 = b;
      return {l0 + 32'd3, l0 + 32'd2, l0 + 32'd1, l0};
   endfunction

   function automatic logic [127:0] plus1(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[32*i +: 32] = d[32*i +: 32] + 32'd1;
      return r;
   endfunction

   // Datapath model plus an injection port for spurious returns.
   logic [LATENCY-1:0] dp_v;
   logic [127:0]       dp_d [LATENCY];
   logic               inj;
   logic [127:0]       inj_data;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         dp_v <= '0;
      end else begin
         dp_v    <= {dp_v[LATENCY-2:0], calc_in_valid};
         dp_d[0] <= plus1(calc_in_data);
         for (int i = 1; i < LATENCY; i++) dp_d[i] <= dp_d[i-1];
      end
   end

   assign calc_out_valid = dp_v[LATENCY-1] | inj;
   assign calc_out_data  = inj ? inj_data : dp_d[LATENCY-1];

   // Output monitor, sampled on the falling edge.
   always @(negedge aclk) begin
      if (aresetn && m_axi4s_tvalid && m_axi4s_tready)
         out_q.push_back('{m_axi4s_tdata, m_axi4s_tlast, cyc});
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic wait_out(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (out_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      n_checks++;
      if (out_q.size() != n) begin
         n_fail++;
         $display("FAIL %s_out_count: got %0d want %0d", name, out_q.size(), n);
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0; s_axi4s_tvalid = 1'b0; s_axi4s_tlast = 1'b0; s_axi4s_tdata = '0;
      m_axi4s_tready = 1'b0; inj = 1'b0; inj_data = '0;
      repeat (3) tick();
      n_checks++; if (s_axi4s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", s_axi4s_tready); end
      n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", m_axi4s_tvalid); end
      n_checks++; if (calc_in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_calc_valid: got %b want 0", calc_in_valid); end
      n_checks++; if ({busy, err_underrun} !== 2'b00) begin n_fail++; $display("FAIL rst_busy_err: got %b want 00", {busy, err_underrun}); end
      aresetn = 1'b1;
      n_checks++; if (s_axi4s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready_pre_edge: got %b want 0", s_axi4s_tready); end
      tick();
      n_checks++; if (s_axi4s_tready !== 1'b1) begin n_fail++; $display("FAIL rst_tready_after: got %b want 1", s_axi4s_tready); end
   endtask

   task automatic test_single_beat();
      out_q.delete();
      m_axi4s_tready = 1'b1;
      s_axi4s_tdata = mk(1); s_axi4s_tlast = 1'b1; s_axi4s_tvalid = 1'b1;
      tick();
      s_axi4s_tvalid = 1'b0; s_axi4s_tlast = 1'b0;
      n_checks++; if (calc_in_valid !== 1'b1) begin n_fail++; $display("FAIL single_calc_valid: got %b want 1", calc_in_valid); end
      n_checks++; if (calc_in_data !== mk(1)) begin n_fail++; $display("FAIL single_calc_data: got %h want %h", calc_in_data, mk(1)); end
      tick();
      n_checks++; if (calc_in_valid !== 1'b0) begin n_fail++; $display("FAIL single_calc_pulse: got %b want 0", calc_in_valid); end
      repeat (LATENCY - 1) tick();
      n_checks++; if (m_axi4s_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_tvalid_early: got %b want 0", m_axi4s_tvalid); end
      tick();
      n_checks++; if (m_axi4s_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid: got %b want 1", m_axi4s_tvalid); end
      n_checks++; if (m_axi4s_tdata !== mk(2)) begin n_fail++; $display("FAIL single_tdata: got %h want %h", m_axi4s_tdata, mk(2)); end
      n_checks++; if ({m_axi4s_tlast, busy} !== 2'b11) begin n_fail++; $display("FAIL single_tlast_busy: got %b want 11", {m_axi4s_tlast, busy}); end
      tick();
      n_checks++; if ({m_axi4s_tvalid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got %b want 00", {m_axi4s_tvalid, busy}); end
      n_checks++; if (out_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", out_q.size()); end
   endtask

   task automatic test_back_to_back();
      int drops;
      out_q.delete();
      drops = 0;
      m_axi4s_tready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         s_axi4s_tdata = mk(1000 + 16*i); s_axi4s_tlast = (i == 63); s_axi4s_tvalid = 1'b1;
         if (!s_axi4s_tready) drops++;
         tick();
      end
      s_axi4s_tvalid = 1'b0; s_axi4s_tlast = 1'b0;
      n_checks++; if (drops != 0) begin n_fail++; $display("FAIL b2b_tready_drops: got %0d want 0", drops); end
      wait_out(64, 200, "b2b");
      for (int i = 0; i < out_q.size() && i < 64; i++) begin
         n_checks++; if (out_q[i].data !== mk(1000 + 16*i + 1) || out_q[i].last !== (i == 63))
            begin n_fail++; $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, mk(1000 + 16*i + 1), (i == 63)); end
         if (i > 0) begin
            n_checks++; if (out_q[i].t != out_q[i-1].t + 1) begin n_fail++; $display("FAIL b2b_gap%0d: got cycle %0d want %0d", i, out_q[i].t, out_q[i-1].t + 1); end
         end
      end
   endtask

   task automatic test_backpressure();
      int k;
      logic acc;
      logic [127:0] held;
      out_q.delete();
      k = 0;
      m_axi4s_tready = 1'b0;
      for (int c = 0; c < 40; c++) begin
         s_axi4s_tdata = mk(5000 + 16*k); s_axi4s_tlast = 1'b0; s_axi4s_tvalid = 1'b1;
         acc = s_axi4s_tready;
         tick();
         if (acc) k++;
      end
      s_axi4s_tvalid = 1'b0;
      n_checks++; if (k != 16) begin n_fail++; $display("FAIL bp_accepted: got %0d want 16", k); end
      n_checks++; if (s_axi4s_tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready_full: got %b want 0", s_axi4s_tready); end
      n_checks++; if (m_axi4s_tdata !== mk(5001) || m_axi4s_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_head: got %h/%b want %h/1", m_axi4s_tdata, m_axi4s_tvalid, mk(5001)); end
      held = m_axi4s_tdata;
      tick();
      n_checks++; if (m_axi4s_tdata !== held) begin n_fail++; $display("FAIL bp_stable: got %h want %h", m_axi4s_tdata, held); end
      m_axi4s_tready = 1'b1;
      wait_out(16, 60, "bp");
      for (int i = 0; i < out_q.size() && i < 16; i++) begin
         n_checks++; if (out_q[i].data !== mk(5000 + 16*i + 1)) begin n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, out_q[i].data, mk(5000 + 16*i + 1)); end
      end
      n_checks++; if ({m_axi4s_tvalid, s_axi4s_tready} !== 2'b01) begin n_fail++; $display("FAIL bp_drained: got %b want 01", {m_axi4s_tvalid, s_axi4s_tready}); end
   endtask

   // Accept, datapath return and FIFO pop all land on the same edge.
   task automatic test_simultaneous();
      out_q.delete();
      m_axi4s_tready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         s_axi4s_tdata = mk(8000 + 16*i); s_axi4s_tvalid = 1'b1;
         tick();
      end
      s_axi4s_tvalid = 1'b0;
      repeat (LATENCY) tick();
      n_checks++; if ({s_axi4s_tready, m_axi4s_tvalid} !== 2'b11) begin n_fail++; $display("FAIL sim_pre: got %b want 11", {s_axi4s_tready, m_axi4s_tvalid}); end
      s_axi4s_tdata = mk(8000 + 16*15); s_axi4s_tvalid = 1'b1; m_axi4s_tready = 1'b1;
      tick();
      s_axi4s_tvalid = 1'b0; m_axi4s_tready = 1'b0;
      n_checks++; if (s_axi4s_tready !== 1'b1) begin n_fail++; $display("FAIL sim_credit_after: got %b want 1", s_axi4s_tready); end
      repeat (LATENCY + 1) tick();
      n_checks++; if (s_axi4s_tready !== 1'b1) begin n_fail++; $display("FAIL sim_credit_15: got %b want 1", s_axi4s_tready); end
      s_axi4s_tdata = mk(8000 + 16*16); s_axi4s_tvalid = 1'b1;
      tick();
      s_axi4s_tvalid = 1'b0;
      n_checks++; if (s_axi4s_tready !== 1'b0) begin n_fail++; $display("FAIL sim_credit_16: got %b want 0", s_axi4s_tready); end
      m_axi4s_tready = 1'b1;
      wait_out(17, 80, "sim");
      for (int i = 0; i < out_q.size() && i < 17; i++) begin
         n_checks++; if (out_q[i].data !== mk(8000 + 16*i + 1)) begin n_fail++; $display("FAIL sim_beat%0d: got %h want %h", i, out_q[i].data, mk(8000 + 16*i + 1)); end
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sim_busy: got %b want 0", busy); end
   endtask

   task automatic test_underrun();
      out_q.delete();
      n_checks++; if (err_underrun !== 1'b0) begin n_fail++; $display("FAIL udr_pre: got %b want 0", err_underrun); end
      inj_data = mk(77); inj = 1'b1;
      tick();
      inj = 1'b0;
      n_checks++; if (err_underrun !== 1'b1) begin n_fail++; $display("FAIL udr_set: got %b want 1", err_underrun); end
      n_checks++; if ({m_axi4s_tvalid, busy} !== 2'b00) begin n_fail++; $display("FAIL udr_fifo: got %b want 00", {m_axi4s_tvalid, busy}); end
      repeat (5) tick();
      n_checks++; if (err_underrun !== 1'b1) begin n_fail++; $display("FAIL udr_sticky: got %b want 1", err_underrun); end
      m_axi4s_tready = 1'b1;
      s_axi4s_tdata = mk(9000); s_axi4s_tlast = 1'b1; s_axi4s_tvalid = 1'b1;
      tick();
      s_axi4s_tvalid = 1'b0; s_axi4s_tlast = 1'b0;
      wait_out(1, 30, "udr");
      repeat (3) tick();
      n_checks++; if (out_q.size() != 1) begin n_fail++; $display("FAIL udr_extra: got %0d want 1", out_q.size()); end
      if (out_q.size() > 0) begin
         n_checks++; if (out_q[0].data !== mk(9001) || out_q[0].last !== 1'b1) begin n_fail++; $display("FAIL udr_beat: got %h/%b want %h/1", out_q[0].data, out_q[0].last, mk(9001)); end
      end
`ifdef EXP_STREAM_PERF_EN
      // Accepted: 1 + 64 + 16 + 17 + 1; stalled: 40 - 16 cycles of the backpressure run.
      n_checks++; if (perf_in_beats !== 32'd99) begin n_fail++; $display("FAIL perf_in_beats: got %0d want 99", perf_in_beats); end
      n_checks++; if (perf_stall_cycles !== 32'd24) begin n_fail++; $display("FAIL perf_stall: got %0d want 24", perf_stall_cycles); end
`else
      n_checks++; if ({perf_in_beats, perf_stall_cycles} !== '0) begin n_fail++; $display("FAIL perf_tied: got %0d/%0d want 0/0", perf_in_beats, perf_stall_cycles); end
`endif
   endtask

   task automatic test_reset_mid_burst();
      out_q.delete();
      m_axi4s_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_axi4s_tdata = mk(12000 + 16*i); s_axi4s_tvalid = 1'b1;
         tick();
      end
      s_axi4s_tvalid = 1'b0;
      repeat (4) tick();
      n_checks++; if ({m_axi4s_tvalid, busy} !== 2'b11 || m_axi4s_tdata !== mk(12001)) begin n_fail++; $display("FAIL rmid_pre: got %b/%h want 11/%h", {m_axi4s_tvalid, busy}, m_axi4s_tdata, mk(12001)); end
      aresetn = 1'b0;
      #1;
      n_checks++; if ({s_axi4s_tready, calc_in_valid, m_axi4s_tvalid, m_axi4s_tlast, busy, err_underrun} !== 6'b0)
         begin n_fail++; $display("FAIL rmid_flags: got %b want 000000", {s_axi4s_tready, calc_in_valid, m_axi4s_tvalid, m_axi4s_tlast, busy, err_underrun}); end
      n_checks++; if (calc_in_data !== '0 || m_axi4s_tdata !== '0) begin n_fail++; $display("FAIL rmid_data: got %h/%h want 0/0", calc_in_data, m_axi4s_tdata); end
      n_checks++; if ({perf_in_beats, perf_stall_cycles} !== '0) begin n_fail++; $display("FAIL rmid_perf: got %0d/%0d want 0/0", perf_in_beats, perf_stall_cycles); end
      repeat (2) tick();
      aresetn = 1'b1;
      tick();
      n_checks++; if (s_axi4s_tready !== 1'b1) begin n_fail++; $display("FAIL rmid_tready: got %b want 1", s_axi4s_tready); end
      out_q.delete();
      m_axi4s_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_axi4s_tdata = mk(13000 + 16*i); s_axi4s_tlast = (i == 3); s_axi4s_tvalid = 1'b1;
         tick();
      end
      s_axi4s_tvalid = 1'b0; s_axi4s_tlast = 1'b0;
      repeat (30) tick();
      n_checks++; if (out_q.size() != 4) begin n_fail++; $display("FAIL rmid_count: got %0d want 4", out_q.size()); end
      for (int i = 0; i < out_q.size() && i < 4; i++) begin
         n_checks++; if (out_q[i].data !== mk(13000 + 16*i + 1) || out_q[i].last !== (i == 3))
            begin n_fail++; $display("FAIL rmid_beat%0d: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, mk(13000 + 16*i + 1), (i == 3)); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_backpressure();
      test_simultaneous();
      test_underrun();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
